// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Runs the request-to-send sequence: clock inhibit, data-low request, then
// start bit, 8 data bits LSB first, odd parity and stop. Bits are clocked by
// the device and the device ACK is checked. The outputs are open-drain enables:
// 1 pulls the line low.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] TX_DATA,
  input  logic       TX_START,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR,
  input  logic       PS2CLK_IN,
  input  logic       PS2DATA_IN,
  output logic       PS2CLK_OE,
  output logic       PS2DATA_OE
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INHIBIT = 3'd1;
  localparam logic [2:0] ST_REQ     = 3'd2;
  localparam logic [2:0] ST_DATA    = 3'd3;
  localparam logic [2:0] ST_ACKWAIT = 3'd4;
  localparam logic [2:0] ST_ERR     = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s;
  logic                   data_s;
  logic                   fe;

  logic [2:0]       state_q,    state_d;
  logic [8:0]       shift_q,    shift_d;
  logic [3:0]       bit_cnt_q,  bit_cnt_d;
  logic [INH_W-1:0] inh_cnt_q,  inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q,   to_cnt_d;
  logic             clk_oe_q,   clk_oe_d;
  logic             data_oe_q,  data_oe_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic             error_q,    error_d;
  logic [3:0]       fe_num;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fe     = clk_prev_q & ~clk_s;
  // Ordinal of the falling edge currently being handled (1..11).
  assign fe_num = bit_cnt_q + 4'd1;

  // Pad synchronizers, preset to the idle (released, pulled-up) level.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q[0]  <= PS2CLK_IN;
      data_sync_q[0] <= PS2DATA_IN;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clk_sync_q[i]  <= clk_sync_q[i-1];
        data_sync_q[i] <= data_sync_q[i-1];
      end
      clk_prev_q <= clk_s;
    end
  end

  // Next-state and next-output logic; all outputs are registered from here.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    clk_oe_d  = 1'b0;
    data_oe_d = 1'b0;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    error_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (TX_START) begin
          shift_d   = {~^TX_DATA, TX_DATA};
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        clk_oe_d = 1'b1;
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          // Data goes low while the clock is still held: request-to-send.
          data_oe_d = 1'b1;
          state_d   = ST_REQ;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
        end
      end

      ST_REQ: begin
        // Release the clock; keep data low as the start bit.
        data_oe_d = 1'b1;
        bit_cnt_d = '0;
        to_cnt_d  = '0;
        state_d   = ST_DATA;
      end

      ST_DATA: begin
        data_oe_d = data_oe_q;
        to_cnt_d  = to_cnt_q + TO_W'(1);
        if (fe) begin
          bit_cnt_d = (bit_cnt_q == 4'd11) ? 4'd11 : fe_num;
          if (fe_num <= 4'd9) begin
            // Data bits then parity, shifted out LSB first.
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[8:1]};
          end else if (fe_num == 4'd10) begin
            data_oe_d = 1'b0;
          end else begin
            // Eleventh edge: the device should be pulling data low as ACK.
            data_oe_d = 1'b0;
            if (data_s) begin
              error_d = 1'b1;
              state_d = ST_ERR;
            end else begin
              state_d = ST_ACKWAIT;
            end
          end
        end
        if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          data_oe_d = 1'b0;
          error_d   = 1'b1;
          state_d   = ST_ERR;
        end
      end

      ST_ACKWAIT: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
        if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          done_d  = 1'b0;
          error_d = 1'b1;
          state_d = ST_ERR;
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      ST_ERR: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset releases both lines immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ERROR      = error_q;
  assign PS2CLK_OE  = clk_oe_q;
  assign PS2DATA_OE = data_oe_q;

endmodule
